commit: RTL and testbench



---
 rtl/commit_pkg.sv | 23 ++
 rtl/commit_fifo.sv | 53 +++++
 rtl/commit.sv | 76 +++++++
 tb/tb_commit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared definitions for the in-order commit stage: record field layout,
// register-file size and the unpacked record type.
package commit_pkg;

  localparam int RD_MSB  = 31;
  localparam int RD_LSB  = 27;
  localparam int VAL_MSB = 26;
  localparam int REG_NUM = 32;

  typedef struct packed {
    logic [RD_MSB-RD_LSB:0] rd;
    logic [VAL_MSB:0]       value;
  } commit_rec_t;

  // Split a raw 32-bit record into destination register and result value.
  function automatic commit_rec_t to_rec(input logic [31:0] raw);
    commit_rec_t rec;
    rec.rd    = raw[RD_MSB:RD_LSB];
    rec.value = raw[VAL_MSB:0];
    return rec;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// In-order retire queue: DEPTH-entry synchronous FIFO. Occupancy is kept in a
// counter one bit wider than the pointers so full and empty are unambiguous.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Empty queue presents zero rather than stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; contents are only visible while occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; occupancy holds on push+pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/commit.sv
// In-order commit stage top. Buffers completed-instruction records, presents
// the oldest one for retirement and, on each retirement handshake, writes its
// result into the architectural register file (r0 stays hard-wired to zero).
// Optional build macro COMMIT_RETIRE_CNT_EN adds a retired-record counter;
// without it retire_cnt is tied to zero.
module commit
  import commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_vaild,
  output logic             req_ready,
  input  logic [31:0]      r_in,
  output logic             rsp_vaild,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  input  logic [4:0]       rf_raddr,
  output logic [31:0]      rf_rdata,
  output logic [CNT_W-1:0] retire_cnt
);

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  commit_rec_t head;
  logic [31:0] rf [REG_NUM];

  // Full queue refuses requests even if it drains this cycle (no bypass).
  assign req_ready = !full;
  assign rsp_vaild = !empty;
  assign push      = req_vaild & req_ready;
  assign pop       = rsp_vaild & rsp_ready;
  assign head      = to_rec(rsp_data);

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (r_in),
    .rdata (rsp_data),
    .full  (full),
    .empty (empty)
  );

  // Architectural register write on retirement; r0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
    end else if (pop && (head.rd != '0)) begin
      rf[head.rd] <= {{(31-VAL_MSB){1'b0}}, head.value};
    end
  end

  // Combinational read, no same-cycle write bypass.
  assign rf_rdata = rf[rf_raddr];

`ifdef COMMIT_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Count every retirement, including rd=0, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (pop) cnt <= cnt + CNT_W'(1);
  end

  assign retire_cnt = cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_commit.sv
// Directed self-checking bench for the commit stage.
module tb_commit;

  logic        clk;
  logic        reset;
  logic        req_vaild;
  logic        req_ready;
  logic [31:0] r_in;
  logic        rsp_vaild;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  commit #(.DEPTH(4), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_vaild  (req_vaild),
    .req_ready  (req_ready),
    .r_in       (r_in),
    .rsp_vaild  (rsp_vaild),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef COMMIT_RETIRE_CNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_vaild = 1'b0; rsp_ready = 1'b0; r_in = '0; rf_raddr = '0;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL reset_rsp_vaild got=%b exp=0", rsp_vaild); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", retire_cnt); end
    rf_raddr = 5'd8; #1;
    checks++; if (rf_rdata !== 32'h0) begin errors++; $display("FAIL reset_rf8 got=%h exp=0", rf_rdata); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_vaild = 1'b1; r_in = 32'h44C7D916; rsp_ready = 1'b1;
    step();
    req_vaild = 1'b0;
    checks++; if (rsp_vaild !== 1'b1) begin errors++; $display("FAIL single_vaild got=%b exp=1", rsp_vaild); end
    checks++; if (rsp_data !== 32'h44C7D916) begin errors++; $display("FAIL single_data got=%h exp=44c7d916", rsp_data); end
    step();
    exp_cnt++;
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", rsp_vaild); end
    rf_raddr = 5'd8; #1;
    checks++; if (rf_rdata !== 32'h04C7D916) begin errors++; $display("FAIL single_rf8 got=%h exp=04c7d916", rf_rdata); end
    checks++; if (retire_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL single_cnt got=%h exp=%h", retire_cnt, cnt_exp(exp_cnt)); end
  endtask

  task automatic test_rd0();
    req_vaild = 1'b1; r_in = 32'h01AAA75C; rsp_ready = 1'b1;
    step();
    req_vaild = 1'b0;
    checks++; if (rsp_data !== 32'h01AAA75C) begin errors++; $display("FAIL rd0_data got=%h exp=01aaa75c", rsp_data); end
    step();
    exp_cnt++;
    rf_raddr = 5'd0; #1;
    checks++; if (rf_rdata !== 32'h0) begin errors++; $display("FAIL rd0_rf0 got=%h exp=0", rf_rdata); end
    checks++; if (retire_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL rd0_cnt got=%h exp=%h", retire_cnt, cnt_exp(exp_cnt)); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] recs [4];
    recs[0] = 32'h4342298A; recs[1] = 32'h3F653322;
    recs[2] = 32'h56C87D33; recs[3] = 32'h3B7D36FD;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_vaild = 1'b1; r_in = recs[i];
      step();
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got=%b exp=0", req_ready); end
    r_in = 32'hDEADBEEF;
    step();
    req_vaild = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_refuse_ready got=%b exp=0", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_data !== recs[i]) begin errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, rsp_data, recs[i]); end
      step();
      exp_cnt++;
    end
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", rsp_vaild); end
    rf_raddr = 5'd8; #1;
    checks++; if (rf_rdata !== 32'h0342298A) begin errors++; $display("FAIL drain_rf8 got=%h exp=0342298a", rf_rdata); end
    rf_raddr = 5'd10; #1;
    checks++; if (rf_rdata !== 32'h06C87D33) begin errors++; $display("FAIL drain_rf10 got=%h exp=06c87d33", rf_rdata); end
    rf_raddr = 5'd7; #1;
    checks++; if (rf_rdata !== 32'h037D36FD) begin errors++; $display("FAIL drain_rf7 got=%h exp=037d36fd", rf_rdata); end
    checks++; if (retire_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL drain_cnt got=%h exp=%h", retire_cnt, cnt_exp(exp_cnt)); end
  endtask

  task automatic test_full_no_bypass();
    logic [31:0] exp_seq [3];
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req_vaild = 1'b1; r_in = {5'(i), 27'h11 * 27'(i)};
      step();
    end
    r_in = 32'h28000055; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL nobyp_full_ready got=%b exp=0", req_ready); end
    step();
    exp_cnt++;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL nobyp_ready_after_pop got=%b exp=1", req_ready); end
    checks++; if (rsp_data !== 32'h10000022) begin errors++; $display("FAIL nobyp_head got=%h exp=10000022", rsp_data); end
    step();
    exp_cnt++;
    req_vaild = 1'b0;
    exp_seq[0] = 32'h18000033; exp_seq[1] = 32'h20000044; exp_seq[2] = 32'h28000055;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_data !== exp_seq[i]) begin errors++; $display("FAIL nobyp_order[%0d] got=%h exp=%h", i, rsp_data, exp_seq[i]); end
      step();
      exp_cnt++;
    end
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL nobyp_empty got=%b exp=0", rsp_vaild); end
    checks++; if (retire_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL nobyp_cnt got=%h exp=%h", retire_cnt, cnt_exp(exp_cnt)); end
  endtask

  task automatic test_one_entry();
    rsp_ready = 1'b0; req_vaild = 1'b1; r_in = 32'h58000001;
    step();
    r_in = 32'h60000002; rsp_ready = 1'b1;
    step();
    exp_cnt++;
    req_vaild = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_vaild !== 1'b1) begin errors++; $display("FAIL one_vaild got=%b exp=1", rsp_vaild); end
    checks++; if (rsp_data !== 32'h60000002) begin errors++; $display("FAIL one_data got=%h exp=60000002", rsp_data); end
    rsp_ready = 1'b1;
    step();
    exp_cnt++;
    rsp_ready = 1'b0;
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL one_occupancy got=%b exp=0", rsp_vaild); end
    rf_raddr = 5'd11; #1;
    checks++; if (rf_rdata !== 32'h00000001) begin errors++; $display("FAIL one_rf11 got=%h exp=00000001", rf_rdata); end
    rf_raddr = 5'd12; #1;
    checks++; if (rf_rdata !== 32'h00000002) begin errors++; $display("FAIL one_rf12 got=%h exp=00000002", rf_rdata); end
    checks++; if (retire_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL one_cnt got=%h exp=%h", retire_cnt, cnt_exp(exp_cnt)); end
  endtask

  task automatic test_reset_mid();
    int bad;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      req_vaild = 1'b1; r_in = {5'(i + 12), 27'h123};
      step();
    end
    req_vaild = 1'b0;
    checks++; if (rsp_vaild !== 1'b1) begin errors++; $display("FAIL mid_pre_vaild got=%b exp=1", rsp_vaild); end
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL mid_vaild got=%b exp=0", rsp_vaild); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL mid_cnt got=%h exp=0", retire_cnt); end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rf_raddr = 5'(a); #0.1;
      if (rf_rdata !== 32'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_rf_clear nonzero_regs=%0d exp=0", bad); end
    step();
    reset = 1'b1;
    step();
    checks++; if (rsp_vaild !== 1'b0) begin errors++; $display("FAIL mid_post_vaild got=%b exp=0", rsp_vaild); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rd0();
    test_fill_drain();
    test_full_no_bypass();
    test_one_entry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
